// File: rtl/vault_pkg.sv
// Shared vault front-end types: entry FSM states,
// controller status codes and default code width.
package vault_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_FULL,
    S_SUBMIT,
    S_LOCKED
  } state_t;

  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_OPEN    = 2'b01;
  localparam logic [1:0] ST_DENIED  = 2'b10;
  localparam logic [1:0] ST_LOCKOUT = 2'b11;

  localparam int CODE_WIDTH_DEF = 4;

endpackage

// File: rtl/button_debounce.sv
// One raw button: 2-flop sync, debounce counter, press pulse.
// Ports: clk, rst (async high), btn (raw), press (1-cycle pulse).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          lvl_q;
  logic          arm_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;
  logic          rise;

  assign rise  = s2_q & ~lvl_q & (cnt_q == CNT_MAX);
  assign press = press_q;

  // Sync flops reset to "pressed" and presses stay disarmed
  // until a released sample is seen, so a button held
  // through reset never produces a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      lvl_q   <= 1'b0;
      arm_q   <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= btn;
      s2_q    <= s1_q;
      press_q <= rise & arm_q;
      if (!s2_q) arm_q <= 1'b1;
      if (s2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        lvl_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad front end: debounced 0/1/ENTER/CLEAR into a code, submit
// pulse, entry_error, timeout auto-clear and lockout freeze.
// Ports: clk, rst, btn_zero/one/enter/clear, vault_status[1:0];
// code_out, submit, digit_count[2:0], entry_error, locked.
module keypad_code_entry
  import vault_pkg::*;
#(
  parameter int CODE_WIDTH      = CODE_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_zero,
  input  logic                  btn_one,
  input  logic                  btn_enter,
  input  logic                  btn_clear,
  input  logic [1:0]            vault_status,
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  submit,
  output logic [2:0]            digit_count,
  output logic                  entry_error,
  output logic                  locked
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    CNT_LAST = 3'(CODE_WIDTH - 1);

  logic e_z, e_o, e_ent, e_clr;
  logic dig, both;

  state_t                state_q;
  logic [CODE_WIDTH-1:0] sh_q;
  logic [CODE_WIDTH-1:0] code_q;
  logic [2:0]            cnt_q;
  logic [TW-1:0]         tmo_q;
  logic                  sub_q, err_q, lock_q;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_zero (
    .clk(clk), .rst(rst), .btn(btn_zero), .press(e_z));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_one (
    .clk(clk), .rst(rst), .btn(btn_one), .press(e_o));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .rst(rst), .btn(btn_enter), .press(e_ent));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .btn(btn_clear), .press(e_clr));

  assign dig  = e_z ^ e_o;
  assign both = e_z & e_o;

  assign code_out    = code_q;
  assign submit      = sub_q;
  assign digit_count = cnt_q;
  assign entry_error = err_q;
  assign locked      = lock_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      code_q  <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      sub_q   <= 1'b0;
      err_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      sub_q <= 1'b0;
      err_q <= 1'b0;
      if (vault_status == ST_LOCKOUT) begin
        // Overrides any same-cycle event; a submit already
        // on the output completes this cycle.
        state_q <= S_LOCKED;
        lock_q  <= 1'b1;
        sh_q    <= '0;
        cnt_q   <= '0;
        tmo_q   <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            tmo_q <= '0;
            if (e_clr) begin
              state_q <= S_IDLE;
            end else if (e_ent || both) begin
              err_q <= 1'b1;
            end else if (dig) begin
              sh_q    <= {sh_q[CODE_WIDTH-2:0], e_o};
              cnt_q   <= 3'd1;
              state_q <= S_COLLECT;
            end
          end
          S_COLLECT, S_FULL: begin
            if (e_clr) begin
              sh_q    <= '0;
              cnt_q   <= '0;
              tmo_q   <= '0;
              state_q <= S_IDLE;
            end else if (e_ent) begin
              tmo_q <= '0;
              if (state_q == S_FULL) begin
                sub_q   <= 1'b1;
                code_q  <= sh_q;
                state_q <= S_SUBMIT;
              end else begin
                err_q   <= 1'b1;
                sh_q    <= '0;
                cnt_q   <= '0;
                state_q <= S_IDLE;
              end
            end else if (both || (dig && state_q == S_FULL)) begin
              err_q <= 1'b1;
              tmo_q <= '0;
            end else if (dig) begin
              sh_q  <= {sh_q[CODE_WIDTH-2:0], e_o};
              cnt_q <= cnt_q + 3'd1;
              tmo_q <= '0;
              if (cnt_q == CNT_LAST) state_q <= S_FULL;
            end else if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              sh_q    <= '0;
              cnt_q   <= '0;
              tmo_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
          S_SUBMIT: begin
            sh_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            state_q <= S_IDLE;
          end
          S_LOCKED: begin
            lock_q <= 1'b1;
            sh_q   <= '0;
            cnt_q  <= '0;
            tmo_q  <= '0;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Randomised + directed bench for keypad_code_entry against
// an event-level model of the entry rules.
module tb_keypad_code_entry;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         b0, b1, be, bc;
  logic [1:0]   vs;
  logic [W-1:0] code_out;
  logic         submit;
  logic [2:0]   digit_count;
  logic         entry_error;
  logic         locked;

  always #5 clk = ~clk;

  keypad_code_entry #(
    .CODE_WIDTH(W),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_zero(b0),
    .btn_one(b1),
    .btn_enter(be),
    .btn_clear(bc),
    .vault_status(vs),
    .code_out(code_out),
    .submit(submit),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .locked(locked)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int sub_seen = 0;
  int err_seen = 0;

  always @(negedge clk) begin
    if (submit) sub_seen++;
    if (entry_error) err_seen++;
  end

  int m_digits[$];
  int m_code;
  int m_sub;
  int m_err;
  bit m_lock;

  function automatic int pack_digits();
    int v = 0;
    foreach (m_digits[i]) v = v * 2 + m_digits[i];
    return v;
  endfunction

  // k: 0 digit0, 1 digit1, 2 enter, 3 clear, 4 both digits
  task automatic model(input int k);
    if (m_lock) return;
    case (k)
      0, 1: begin
        if (m_digits.size() < W) m_digits.push_back(k);
        else m_err++;
      end
      2: begin
        if (m_digits.size() == W) begin
          m_sub++;
          m_code = pack_digits();
        end else begin
          m_err++;
        end
        m_digits.delete();
      end
      3: m_digits.delete();
      default: m_err++;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(digit_count), 32'(m_digits.size()));
    chk({tag, ".submits"}, 32'(sub_seen), 32'(m_sub));
    chk({tag, ".errors"}, 32'(err_seen), 32'(m_err));
    chk({tag, ".code"}, 32'(code_out), 32'(m_code));
    chk({tag, ".locked"}, 32'(locked), 32'(m_lock));
  endtask

  task automatic press(input int k);
    @(negedge clk);
    b0 = (k == 0 || k == 4);
    b1 = (k == 1 || k == 4);
    be = (k == 2);
    bc = (k == 3);
    repeat (10) @(negedge clk);
    b0 = 0; b1 = 0; be = 0; bc = 0;
    repeat (10) @(negedge clk);
    model(k);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    m_digits.delete();
    m_code = 0;
    m_lock = 0;
    rst = 0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int r;
    rst = 1; b0 = 0; b1 = 0; be = 0; bc = 0; vs = 2'b00;
    m_code = 0; m_sub = 0; m_err = 0; m_lock = 0;
    repeat (3) @(negedge clk);
    chk("reset.count", 32'(digit_count), 0);
    chk("reset.submit", 32'(submit), 0);
    chk("reset.error", 32'(entry_error), 0);
    chk("reset.code", 32'(code_out), 0);
    chk("reset.locked", 32'(locked), 0);
    rst = 0;
    repeat (4) @(negedge clk);

    // code 1011 then ENTER
    press(1); press(0); press(1); press(1);
    check_all("full4");
    press(2);
    check_all("submit1011");

    // bouncing one-press
    @(negedge clk); b1 = 1;
    @(negedge clk); b1 = 0;
    @(negedge clk); b1 = 1;
    @(negedge clk); b1 = 0;
    @(negedge clk); b1 = 1;
    repeat (10) @(negedge clk);
    b1 = 0;
    repeat (10) @(negedge clk);
    model(1);
    check_all("bounce");
    press(3);
    check_all("clear1");

    // short ENTER, ENTER in IDLE, both-digits
    press(1); press(0); press(2);
    check_all("short_enter");
    press(2);
    check_all("idle_enter");
    press(1); press(4);
    check_all("both_digits");
    press(3);

    // five digits then ENTER
    press(1); press(0); press(1); press(1); press(0);
    check_all("fifth_digit");
    press(2);
    check_all("submit_after5");

    // timeout
    press(1); press(1);
    repeat (50) @(negedge clk);
    m_err++;
    m_digits.delete();
    check_all("timeout");

    // clear after three
    press(1); press(0); press(1); press(3);
    check_all("clear3");

    // randomised event stream, non-lockout status values
    for (int i = 0; i < 40; i++) begin
      vs = 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      press(r < 4 ? 0 : r < 8 ? 1 : r == 8 ? 2 : 3);
      check_all("random");
    end
    vs = 2'b00;
    press(3);

    // lockout mid-entry
    press(1); press(0);
    @(negedge clk); vs = 2'b11;
    @(negedge clk);
    m_lock = 1;
    m_digits.delete();
    check_all("lockout");
    vs = 2'b00;
    press(1); press(1); press(1); press(1); press(2);
    check_all("locked_ignore");
    do_reset();
    check_all("unlock_rst");

    // reset during held press
    @(negedge clk); b1 = 1;
    repeat (3) @(negedge clk);
    do_reset();
    repeat (20) @(negedge clk);
    check_all("held_through_rst");
    b1 = 0;
    repeat (10) @(negedge clk);
    check_all("held_release");
    press(1);
    check_all("repress");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
